rf_writeback_scheduler: RTL

// - Initiator side of the 128x64 register-file write interface (4 write ports, byte masks).
// - Collects writeback requests from NUM_SRC execution units over valid/ready.
// - Issues up to NUM_PORTS masked writes per cycle on registered write-port outputs.
// - Never presents two same-address writes in one cycle, so port-to-port write ordering in the RF is irrelevant.

---
 rtl/rf_wb_pkg.sv | 18 +
 rtl/rf_wb_rr_picker.sv | 80 ++++++++
 rtl/rf_writeback_scheduler.sv | 103 ++++++++++
 3 files changed

// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared widths and request types for the RF writeback scheduler
package rf_wb_pkg;

  localparam int NUM_SRC   = 8;
  localparam int NUM_PORTS = 4;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 64;
  localparam int MASK_W    = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] value;
    logic [MASK_W-1:0] mask;
  } rf_wr_req_t;

  typedef rf_wr_req_t [NUM_PORTS-1:0] rf_wr_ports_t;

endpackage

// File: rtl/rf_wb_rr_picker.sv
// rtl/rf_wb_rr_picker.sv - rotating scan that grants pending entries to write ports
module rf_wb_rr_picker
  import rf_wb_pkg::*;
#(
  parameter  int NUM_SRC   = 8,
  parameter  int NUM_PORTS = 4,
  localparam int SRC_W     = $clog2(NUM_SRC),
  localparam int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_SRC-1:0]                pending,
  input  logic [NUM_SRC-1:0]                mask_zero,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0]    addr,
  input  logic [SRC_W-1:0]                  rr_ptr,
  output logic [NUM_SRC-1:0]                grant,
  output logic [NUM_PORTS-1:0]              port_valid,
  output logic [NUM_PORTS-1:0][SRC_W-1:0]   port_src,
  output logic [SRC_W-1:0]                  next_ptr,
  output logic                              conflict
);

  localparam logic [SRC_W:0]  SRC_L   = (SRC_W+1)'(NUM_SRC);
  localparam logic [PORT_W:0] PORTS_L = (PORT_W+1)'(NUM_PORTS);

  always_comb begin
    logic [SRC_W:0]                  pos;
    logic [SRC_W:0]                  nxt;
    logic [SRC_W-1:0]                idx;
    logic [PORT_W:0]                 used;
    logic [NUM_PORTS-1:0]            slot_busy;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] slot_addr;
    logic                            hit;

    grant      = '0;
    port_valid = '0;
    port_src   = '0;
    next_ptr   = rr_ptr;
    conflict   = 1'b0;
    pos        = '0;
    nxt        = '0;
    idx        = '0;
    used       = '0;
    slot_busy  = '0;
    slot_addr  = '0;
    hit        = 1'b0;

    for (int k = 0; k < NUM_SRC; k++) begin
      pos = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (pos >= SRC_L) pos = pos - SRC_L;
      idx = pos[SRC_W-1:0];
      nxt = pos + (SRC_W+1)'(1);
      if (nxt == SRC_L) nxt = '0;

      hit = 1'b0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (slot_busy[j] && (slot_addr[j] == addr[idx])) hit = 1'b1;
      end

      // Empty-mask entries retire without a port; a deferral only counts when a port was free.
      if (pending[idx]) begin
        if (mask_zero[idx]) begin
          grant[idx] = 1'b1;
          next_ptr   = nxt[SRC_W-1:0];
        end else if (used != PORTS_L) begin
          if (hit) begin
            conflict = 1'b1;
          end else begin
            grant[idx]                    = 1'b1;
            port_valid[used[PORT_W-1:0]]  = 1'b1;
            port_src[used[PORT_W-1:0]]    = idx;
            slot_busy[used[PORT_W-1:0]]   = 1'b1;
            slot_addr[used[PORT_W-1:0]]   = addr[idx];
            used                          = used + (PORT_W+1)'(1);
            next_ptr                      = nxt[SRC_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: rtl/rf_writeback_scheduler.sv
// rtl/rf_writeback_scheduler.sv - per-source holding registers feeding registered RF write ports
module rf_writeback_scheduler
  import rf_wb_pkg::*;
#(
  parameter  int NUM_SRC   = rf_wb_pkg::NUM_SRC,
  parameter  int NUM_PORTS = rf_wb_pkg::NUM_PORTS,
  localparam int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_SRC-1:0]            io_req_valid,
  output logic [NUM_SRC-1:0]            io_req_ready,
  input  logic [NUM_SRC*ADDR_W-1:0]     io_req_address,
  input  logic [NUM_SRC*DATA_W-1:0]     io_req_value,
  input  logic [NUM_SRC*MASK_W-1:0]     io_req_byteMask,
  output logic [NUM_PORTS-1:0]          io_write_write,
  output logic [NUM_PORTS*ADDR_W-1:0]   io_write_address,
  output logic [NUM_PORTS*DATA_W-1:0]   io_write_value,
  output logic [NUM_PORTS*MASK_W-1:0]   io_write_byteMask,
  output logic                          io_busy,
  output logic [15:0]                   io_conflict_cycles
);

  rf_wr_req_t [NUM_SRC-1:0]           req_in;
  rf_wr_req_t [NUM_SRC-1:0]           ent_q;
  logic [NUM_SRC-1:0]                 pending_q;
  logic [SRC_W-1:0]                   rr_ptr_q;
  rf_wr_req_t [NUM_PORTS-1:0]         port_q;
  logic [NUM_PORTS-1:0]               wr_q;
  logic [15:0]                        conflict_q;

  logic [NUM_SRC-1:0]                 mask_zero;
  logic [NUM_SRC-1:0][ADDR_W-1:0]     ent_addr;
  logic [NUM_SRC-1:0]                 grant;
  logic [NUM_PORTS-1:0]               port_valid;
  logic [NUM_PORTS-1:0][SRC_W-1:0]    port_src;
  logic [SRC_W-1:0]                   next_ptr;
  logic                               conflict;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign req_in[i]    = {io_req_address[i*ADDR_W +: ADDR_W],
                           io_req_value[i*DATA_W +: DATA_W],
                           io_req_byteMask[i*MASK_W +: MASK_W]};
    assign ent_addr[i]  = ent_q[i].addr;
    assign mask_zero[i] = (ent_q[i].mask == '0);
  end

  // Grant comes from registered state only, so ready never depends on valid.
  assign io_req_ready = ~pending_q | grant;
  assign io_busy      = |pending_q;

  rf_wb_rr_picker #(
    .NUM_SRC   (NUM_SRC),
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .pending    (pending_q),
    .mask_zero  (mask_zero),
    .addr       (ent_addr),
    .rr_ptr     (rr_ptr_q),
    .grant      (grant),
    .port_valid (port_valid),
    .port_src   (port_src),
    .next_ptr   (next_ptr),
    .conflict   (conflict)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent_q      <= '0;
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      port_q     <= '0;
      wr_q       <= '0;
      conflict_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (io_req_valid[i] && io_req_ready[i]) begin
          ent_q[i]     <= req_in[i];
          pending_q[i] <= 1'b1;
        end else if (grant[i]) begin
          pending_q[i] <= 1'b0;
        end
      end
      // Idle ports drop write but keep their last address/data/mask.
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_q[p] <= port_valid[p];
        if (port_valid[p]) port_q[p] <= ent_q[port_src[p]];
      end
      rr_ptr_q <= next_ptr;
      if (conflict && (conflict_q != 16'hFFFF)) conflict_q <= conflict_q + 16'd1;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign io_write_address[p*ADDR_W +: ADDR_W]  = port_q[p].addr;
    assign io_write_value[p*DATA_W +: DATA_W]    = port_q[p].value;
    assign io_write_byteMask[p*MASK_W +: MASK_W] = port_q[p].mask;
  end

  assign io_write_write     = wr_q;
  assign io_conflict_cycles = conflict_q;

endmodule
